aes_result_scroller: RTL and testbench

Downstream display stage for the AES encrypt/decrypt datapath. It captures a finished 128-bit block on a load pulse and cycles through all 16 bytes. Each byte is converted to decimal (0–255) by a sequential 8-step double-dabble and driven onto three active-low seven-segment digits for a programmable dwell time. This replaces the single-byte combinational display at the top level.

---
 rtl/aes_result_scroller.sv | 188 ++++++++++++++++++
 tb/tb_aes_result_scroller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_result_scroller.sv
// Display stage for the AES datapath: captures a 128-bit block and scrolls its 16 bytes
// as decimal values (double-dabble, one step per cycle) on three active-low 7-segment digits.
module aes_result_scroller #(
    parameter int DWELL = 50000000,
    parameter int CW    = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [127:0] block_in,
    input  logic         pause,
    output logic         busy,
    output logic         valid,
    output logic [3:0]   byte_idx,
    output logic [7:0]   byte_val,
    output logic [6:0]   HEX2,
    output logic [6:0]   HEX1,
    output logic [6:0]   HEX0
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SHOW    = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_DWELL = CW'(DWELL - 1);
    localparam logic [6:0]    SEG_BLANK  = 7'h7F;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    // Layout {hundreds, tens, units, binary}: adjust each BCD nibble, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t        = s;
        t[19:16] = (t[19:16] >= 4'd5) ? t[19:16] + 4'd3 : t[19:16];
        t[15:12] = (t[15:12] >= 4'd5) ? t[15:12] + 4'd3 : t[15:12];
        t[11:8]  = (t[11:8]  >= 4'd5) ? t[11:8]  + 4'd3 : t[11:8];
        dd_step  = {t[18:0], 1'b0};
    endfunction

    state_t         r_state;
    state_t         w_state_nx;
    logic [127:0]   r_block;
    logic [3:0]     r_idx;
    logic [7:0]     r_cur;
    logic [19:0]    r_sh;
    logic [2:0]     r_cnt;
    logic [CW-1:0]  r_dwell;
    logic           r_busy;
    logic           r_valid;
    logic [3:0]     r_byte_idx;
    logic [7:0]     r_byte_val;
    logic [6:0]     r_hex2;
    logic [6:0]     r_hex1;
    logic [6:0]     r_hex0;

    logic [3:0]     w_next_idx;
    logic [7:0]     w_next_byte;
    logic [19:0]    w_sh_nx;
    logic [3:0]     w_hund;
    logic [3:0]     w_tens;
    logic [3:0]     w_unit;
    logic           w_step;
    logic           w_done;
    logic           w_adv;

    assign w_next_idx  = r_idx + 4'd1;
    assign w_next_byte = r_block[{~w_next_idx, 3'b000} +: 8];
    assign w_sh_nx     = dd_step(r_sh);
    assign w_hund      = w_sh_nx[19:16];
    assign w_tens      = w_sh_nx[15:12];
    assign w_unit      = w_sh_nx[11:8];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic; load overrides every transition.
    always_comb begin
        w_state_nx = r_state;
        if (load) begin
            w_state_nx = S_CONVERT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_nx = S_IDLE;
                S_CONVERT: w_state_nx = (r_cnt == 3'd7) ? S_SHOW : S_CONVERT;
                S_SHOW:    w_state_nx = (!pause && r_dwell == LAST_DWELL) ? S_CONVERT : S_SHOW;
                default:   w_state_nx = S_IDLE;
            endcase
        end
    end

    // Control strobes decoded from the current state.
    always_comb begin
        w_step = 1'b0;
        w_done = 1'b0;
        w_adv  = 1'b0;
        case (r_state)
            S_CONVERT: begin
                w_step = 1'b1;
                w_done = !load && (r_cnt == 3'd7);
            end
            S_SHOW: begin
                w_adv = !load && !pause && (r_dwell == LAST_DWELL);
            end
            default: begin
                w_step = 1'b0;
            end
        endcase
    end

    // Datapath: capture, conversion shift register, dwell timing and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_block    <= 128'd0;
            r_idx      <= 4'd0;
            r_cur      <= 8'd0;
            r_sh       <= 20'd0;
            r_cnt      <= 3'd0;
            r_dwell    <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_byte_idx <= 4'd0;
            r_byte_val <= 8'd0;
            r_hex2     <= SEG_BLANK;
            r_hex1     <= SEG_BLANK;
            r_hex0     <= SEG_BLANK;
        end else begin
            r_busy <= (w_state_nx != S_IDLE);
            if (load) begin
                r_block <= block_in;
                r_idx   <= 4'd0;
                r_cur   <= block_in[127:120];
                r_sh    <= {12'd0, block_in[127:120]};
                r_cnt   <= 3'd0;
            end else if (w_adv) begin
                r_idx <= w_next_idx;
                r_cur <= w_next_byte;
                r_sh  <= {12'd0, w_next_byte};
                r_cnt <= 3'd0;
            end else if (w_step) begin
                r_sh  <= w_sh_nx;
                r_cnt <= r_cnt + 3'd1;
                if (w_done) begin
                    r_byte_idx <= r_idx;
                    r_byte_val <= r_cur;
                    r_valid    <= 1'b1;
                    r_dwell    <= '0;
                    r_hex2     <= (w_hund == 4'd0) ? SEG_BLANK : seg7(w_hund);
                    // Tens blank only when the whole value is below ten.
                    r_hex1     <= (w_hund == 4'd0 && w_tens == 4'd0) ? SEG_BLANK : seg7(w_tens);
                    r_hex0     <= seg7(w_unit);
                end
            end else if (r_state == S_SHOW && !pause) begin
                r_dwell <= r_dwell + CW'(1);
            end
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign byte_idx = r_byte_idx;
    assign byte_val = r_byte_val;
    assign HEX2     = r_hex2;
    assign HEX1     = r_hex1;
    assign HEX0     = r_hex0;

endmodule

// File: tb/tb_aes_result_scroller.sv
// Self-checking bench: directed scenarios plus randomized load/pause/reset traffic,
// compared each cycle against an event-schedule model of the scroller.
module tb_aes_result_scroller;

    localparam int DWELL = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [127:0] block_in;
    logic         pause;
    logic         busy;
    logic         valid;
    logic [3:0]   byte_idx;
    logic [7:0]   byte_val;
    logic [6:0]   HEX2;
    logic [6:0]   HEX1;
    logic [6:0]   HEX0;

    aes_result_scroller #(.DWELL(DWELL), .CW(26)) dut (
        .clk(clk), .reset(reset), .load(load), .block_in(block_in), .pause(pause),
        .busy(busy), .valid(valid), .byte_idx(byte_idx), .byte_val(byte_val),
        .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: display events scheduled by cycle number.
    logic [127:0] m_block;
    int  cyc;
    int  m_next_evt;
    int  m_idx_next;
    int  m_idx_show;
    int  m_show_left;
    bit  m_in_show;
    bit  m_shown;
    bit  m_valid;
    bit  m_busy;
    int  m_val;
    logic [6:0] seg_tab [10];

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    end

    function automatic int byte_of(input logic [127:0] b, input int k);
        logic [127:0] s;
        s = b >> (8 * (15 - k));
        return int'(s[7:0]);
    endfunction

    function automatic logic [6:0] exp_digit(input int v, input int pos);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (pos == 2) return (h == 0) ? 7'h7F : seg_tab[h];
        if (pos == 1) return (v < 10) ? 7'h7F : seg_tab[t];
        return seg_tab[u];
    endfunction

    task automatic model_reset();
        m_block = 128'd0; m_next_evt = -1; m_idx_next = 0; m_idx_show = 0;
        m_show_left = 0; m_in_show = 0; m_shown = 0; m_valid = 0; m_busy = 0; m_val = 0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (load) begin
            m_block = block_in; m_busy = 1; m_idx_next = 0;
            m_next_evt = cyc + 8; m_in_show = 0;
        end else if (m_next_evt == cyc) begin
            m_shown = 1; m_valid = 1; m_idx_show = m_idx_next;
            m_val = byte_of(m_block, m_idx_show);
            m_in_show = 1; m_show_left = DWELL; m_next_evt = -1;
        end else if (m_in_show && !pause) begin
            m_show_left--;
            if (m_show_left == 0) begin
                m_in_show = 0;
                m_idx_next = (m_idx_show + 1) % 16;
                m_next_evt = cyc + 8;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("valid", {31'd0, valid}, {31'd0, m_valid});
        check("byte_idx", {28'd0, byte_idx}, m_idx_show);
        check("byte_val", {24'd0, byte_val}, m_val);
        check("HEX2", {25'd0, HEX2}, {25'd0, m_shown ? exp_digit(m_val, 2) : 7'h7F});
        check("HEX1", {25'd0, HEX1}, {25'd0, m_shown ? exp_digit(m_val, 1) : 7'h7F});
        check("HEX0", {25'd0, HEX0}, {25'd0, m_shown ? exp_digit(m_val, 0) : 7'h7F});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [127:0] b);
        block_in = b;
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        reset = 1'b1; load = 1'b0; pause = 1'b0; block_in = 128'd0;
        run(2);
        reset = 1'b0;
        run(50);
        check("idle_hex2", {25'd0, HEX2}, 32'h7F);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Reference block: byte k appears at L+8+12k.
        do_load(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run(8);
        check("b0_val", {24'd0, byte_val}, 32'h69);
        check("b0_hex2", {25'd0, HEX2}, 32'b1111001);
        check("b0_hex1", {25'd0, HEX1}, 32'b1000000);
        check("b0_hex0", {25'd0, HEX0}, 32'b0010010);
        run(12);
        check("b1_idx", {28'd0, byte_idx}, 32'd1);
        check("b1_val", {24'd0, byte_val}, 32'hc4);
        check("b1_hex0", {25'd0, HEX0}, 32'b0000010);
        run(168);
        check("b15_idx", {28'd0, byte_idx}, 32'd15);
        check("b15_val", {24'd0, byte_val}, 32'h5a);
        check("b15_hex2", {25'd0, HEX2}, 32'h7F);
        check("b15_hex1", {25'd0, HEX1}, 32'b0010000);
        check("b15_hex0", {25'd0, HEX0}, 32'b1000000);
        run(12);
        check("wrap_idx", {28'd0, byte_idx}, 32'd0);

        // Pause in SHOW stretches the dwell.
        run(1);
        pause = 1'b1;
        run(30);
        check("pause_idx", {28'd0, byte_idx}, 32'd0);
        pause = 1'b0;
        run(11);
        check("pause_rel_idx", {28'd0, byte_idx}, 32'd1);
        // Pause during conversion does not move the completion edge.
        run(6);
        pause = 1'b1;
        run(6);
        pause = 1'b0;
        run(10);

        // Leading-zero blanking.
        do_load({8'h00, 8'hFF, 8'h0A, 104'h0102030405060708090a0b0c0d});
        run(8);
        check("z_hex2", {25'd0, HEX2}, 32'h7F);
        check("z_hex1", {25'd0, HEX1}, 32'h7F);
        check("z_hex0", {25'd0, HEX0}, 32'b1000000);
        run(12);
        check("ff_hex2", {25'd0, HEX2}, 32'b0100100);
        run(12);
        check("0a_hex2", {25'd0, HEX2}, 32'h7F);
        check("0a_hex1", {25'd0, HEX1}, 32'b1111001);

        // Second load during CONVERT of byte 3: byte 3 conversion spans L+36..L+44.
        run(7);
        do_load({8'hFE, 120'h123456789abcdef0123456789abc});
        check("mid_hold_idx", {28'd0, byte_idx}, 32'd2);
        run(8);
        check("mid_idx", {28'd0, byte_idx}, 32'd0);
        check("mid_hex2", {25'd0, HEX2}, 32'b0100100);
        check("mid_hex1", {25'd0, HEX1}, 32'b0010010);
        check("mid_hex0", {25'd0, HEX0}, 32'b0011001);

        // Reset during SHOW of byte 5 (shown at L+68).
        run(61);
        check("pre_rst_idx", {28'd0, byte_idx}, 32'd5);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_hex0", {25'd0, HEX0}, 32'h7F);
        check("rst_valid", {31'd0, valid}, 32'd0);
        run(20);
        check("rst_idle_busy", {31'd0, busy}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            pause    = ($urandom_range(0, 3) == 0);
            reset    = ($urandom_range(0, 699) == 0);
            load     = ($urandom_range(0, 149) == 0) || (i == 0);
            block_in = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        reset = 1'b0; load = 1'b0; pause = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
